voice_allocator: RTL and testbench
==================================

# voice_allocator

Polyphonic voice allocator and lookup scheduler for the synth. It accepts note-on/note-off key events, assigns each note-on to one of `NUM_VOICES` oscillator voices, and sequences the single shared note-frequency table to fetch that voice's frequency. It also drives per-voice frequency/gate/load registers into the oscillator bank. It sits between the keyboard/PS2 decoder and the voice oscillators.

## Interface
- `NUM_VOICES`, 4: number of voices, 2..8.
- `FREQ_W`, 21: frequency word width, units of 0.01 Hz.
- `AGE_W`, 8: per-voice age counter width.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `ev_valid` in 1: key event present.
- `ev_ready` out 1: allocator can accept an event.
- `ev_on` in 1: 1 = note-on, 0 = note-off.
- `ev_note` in 4: semitone, legal range 0..11.
- `ev_octave` in 3: octave 0..7.
- `lut_index` out 7: address to shared frequency table.
- `lut_freq` in FREQ_W: table data, registered, valid 1 cycle after `lut_index`.
- `voice_freq` out NUM_VOICES*FREQ_W: voice v at bits [v*FREQ_W +: FREQ_W].
- `voice_gate` out NUM_VOICES: voice sounding.
- `voice_load` out NUM_VOICES: 1-cycle pulse when `voice_freq[v]` changes.
- `drop` out 1: 1-cycle pulse, event rejected because `ev_note` > 11.

## Operation
- Key index = `ev_octave`*12 + `ev_note` (0..95), computed in 7 bits, no overflow. Captured on accept. Each voice stores its key index.
- FSM states:
  - IDLE: `ev_ready`=1.
  - Accept on `ev_valid & ev_ready`:
    - note > 11 → REJECT.
    - note-on → LOOKUP.
    - note-off → RELEASE.
  - LOOKUP: drive `lut_index` = key index → WRITE.
  - WRITE: sample `lut_freq` and update the target voice → IDLE.
  - RELEASE: every voice with gate=1 and matching key gets gate cleared → IDLE. No match: no change.
  - REJECT: `drop`=1 → IDLE.
- Target voice selection for note-on, in priority order:
  1. A gated voice with the same key index: retrigger.
  2. Otherwise the lowest-index voice with gate=0.
  3. Otherwise steal the voice with the largest age, ties to the lowest index.
- On WRITE:
  - Target: freq = `lut_freq`, gate = 1, age = 0, key stored, `voice_load` bit pulses.
  - Every other gated voice: age increments, saturating at 2^AGE_W−1.
- A retrigger still reloads and pulses `voice_load`, even when the frequency is unchanged.
- `lut_index` holds its last value outside LOOKUP.

## Timing
- Reset values:
  - State IDLE; `ev_ready`=1.
  - All voice freq/gate/load/age/key = 0.
  - `lut_index`=0, `drop`=0.
- Reset asserted mid-operation: the event is abandoned, no `voice_load` pulse, and outputs take reset values on the next cycle.
- Note-on accepted at edge of cycle T:
  - T+1 LOOKUP, `lut_index` valid.
  - T+2 WRITE, `lut_freq` sampled.
  - T+3: new `voice_freq`/`voice_gate` visible, `voice_load` high for this cycle only, `ev_ready`=1.
- Note-off accepted at T:
  - T+1 RELEASE.
  - T+2: gate low, `ev_ready`=1.
- Rejected note accepted at T: `drop` high in T+1, `ev_ready`=1 in T+2.
- `ev_ready` is 0 in every non-IDLE state. Upstream holds `ev_*` stable while `ev_valid` & !`ev_ready`.
- Maximum throughput: one note-on per 3 cycles, one note-off per 2 cycles.
- A released voice keeps its `voice_freq` (release tail).

## Structure
- Shared package `synth_pkg`:
  - `NOTES_PER_OCTAVE`=12, `FREQ_W`=21, `KEY_IDX_W`=7.
  - FSM state enum {IDLE, LOOKUP, WRITE, RELEASE, REJECT}.
- The frequency table stays outside this block; the allocator is its sole master.
- Sub-module `voice_select`: combinational match/free/oldest search over gate, key and age vectors, returning the target voice index.

## Test plan
- Reset, then note-on (note 9, octave 4); table returns 44000 for index 57 → `lut_index`=57 at T+1; voice 0 freq=44000, gate=1, `voice_load`=0001 at T+3.
- Note-on C0 (0,0) then D0 (2,0) → voice 0 freq=1635, voice 1 freq=1835, both gated. Then note-off (0,0) → voice 0 gate=0 at T+2, voice 1 unchanged.
- Four note-ons at indices 0,12,24,36 with NUM_VOICES=4, then index 48 → voice 0 (largest age 3) stolen: key 48, age 0, others aged.
- Note-on index 57 twice → second event retriggers the same voice; `voice_load` pulses again and no second voice is gated.
- `ev_note`=13 → `drop` pulse at T+1, no `lut_index` change, voice state unchanged; `ev_ready` low exactly one cycle.
- Reset asserted during WRITE → no `voice_load` pulse; all outputs 0 and `ev_ready`=1 on the next cycle.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared synth definitions: key/frequency widths, allocator FSM states and key-index helper.
package synth_pkg;

  localparam int unsigned NOTES_PER_OCTAVE = 12;
  localparam int unsigned FREQ_W           = 21;
  localparam int unsigned KEY_IDX_W        = 7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    WRITE   = 3'd2,
    RELEASE = 3'd3,
    REJECT  = 3'd4
  } state_e;

  // octave*12 + note; the 7-bit result cannot overflow for octave<=7, note<=15
  function automatic logic [KEY_IDX_W-1:0] key_index(input logic [2:0] octave,
                                                     input logic [3:0] note);
    return KEY_IDX_W'(octave) * KEY_IDX_W'(NOTES_PER_OCTAVE) + KEY_IDX_W'(note);
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Key-event handshake, frequency-table port and oscillator-bank outputs of the voice allocator.
interface voice_allocator_if #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned FREQ_W     = 21
);
  import synth_pkg::*;

  logic                         ev_valid;
  logic                         ev_ready;
  logic                         ev_on;
  logic [3:0]                   ev_note;
  logic [2:0]                   ev_octave;
  logic [KEY_IDX_W-1:0]         lut_index;
  logic [FREQ_W-1:0]            lut_freq;
  logic [NUM_VOICES*FREQ_W-1:0] voice_freq;
  logic [NUM_VOICES-1:0]        voice_gate;
  logic [NUM_VOICES-1:0]        voice_load;
  logic                         drop;

  modport master (
    output ev_valid, ev_on, ev_note, ev_octave, lut_freq,
    input  ev_ready, lut_index, voice_freq, voice_gate, voice_load, drop
  );

  modport slave (
    input  ev_valid, ev_on, ev_note, ev_octave, lut_freq,
    output ev_ready, lut_index, voice_freq, voice_gate, voice_load, drop
  );

endinterface

// File: rtl/voice_select.sv
// Combinational target-voice search: retrigger match, else lowest free voice, else oldest voice.
module voice_select
  import synth_pkg::*;
#(
  parameter  int unsigned NUM_VOICES = 4,
  parameter  int unsigned AGE_W      = 8,
  localparam int unsigned IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0]                gate,
  input  logic [NUM_VOICES-1:0][KEY_IDX_W-1:0] keys,
  input  logic [NUM_VOICES-1:0][AGE_W-1:0]     ages,
  input  logic [KEY_IDX_W-1:0]                 key,
  output logic [IDX_W-1:0]                     target_c
);

  logic             match_hit;
  logic             free_hit;
  logic [IDX_W-1:0] match_idx;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] old_idx;
  logic [AGE_W-1:0] old_age;

  // Ascending scans with first-hit flags give lowest-index priority; strict '>' keeps age ties low
  always_comb begin
    match_hit = 1'b0;
    free_hit  = 1'b0;
    match_idx = '0;
    free_idx  = '0;
    old_idx   = '0;
    old_age   = ages[0];
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (gate[v] && (keys[v] == key) && !match_hit) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(v);
      end
      if (!gate[v] && !free_hit) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(v);
      end
      if (ages[v] > old_age) begin
        old_age = ages[v];
        old_idx = IDX_W'(v);
      end
    end
    if (match_hit) begin
      target_c = match_idx;
    end else if (free_hit) begin
      target_c = free_idx;
    end else begin
      target_c = old_idx;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: accepts key events, sequences the shared frequency table, drives voice registers.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned FREQ_W     = 21,
  parameter int unsigned AGE_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  voice_allocator_if.slave bus
);
  import synth_pkg::*;

  localparam int unsigned      IDX_W   = $clog2(NUM_VOICES);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  state_e                                state, state_nxt;
  logic                                  ev_ready_q;
  logic                                  drop_q, drop_nxt;
  logic [KEY_IDX_W-1:0]                  key_q, key_nxt;
  logic [KEY_IDX_W-1:0]                  lut_index_q, lut_index_nxt;
  logic [NUM_VOICES-1:0][FREQ_W-1:0]     freq_q, freq_nxt;
  logic [NUM_VOICES-1:0]                 gate_q, gate_nxt;
  logic [NUM_VOICES-1:0]                 load_q, load_nxt;
  logic [NUM_VOICES-1:0][KEY_IDX_W-1:0]  keys_q, keys_nxt;
  logic [NUM_VOICES-1:0][AGE_W-1:0]      ages_q, ages_nxt;
  logic [IDX_W-1:0]                      target_c;
  logic                                  accept_c;
  logic [KEY_IDX_W-1:0]                  key_in_c;

  assign accept_c = bus.ev_valid & ev_ready_q;
  assign key_in_c = key_index(bus.ev_octave, bus.ev_note);

  voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W)
  ) u_voice_select (
    .gate     (gate_q),
    .keys     (keys_q),
    .ages     (ages_q),
    .key      (key_q),
    .target_c (target_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ev_ready_q  <= 1'b1;
      drop_q      <= 1'b0;
      key_q       <= '0;
      lut_index_q <= '0;
      freq_q      <= '0;
      gate_q      <= '0;
      load_q      <= '0;
      keys_q      <= '0;
      ages_q      <= '0;
    end else begin
      state       <= state_nxt;
      ev_ready_q  <= (state_nxt == IDLE);
      drop_q      <= drop_nxt;
      key_q       <= key_nxt;
      lut_index_q <= lut_index_nxt;
      freq_q      <= freq_nxt;
      gate_q      <= gate_nxt;
      load_q      <= load_nxt;
      keys_q      <= keys_nxt;
      ages_q      <= ages_nxt;
    end
  end

  // Next state and next register values; load and drop default low so they pulse for one cycle
  always_comb begin
    state_nxt     = state;
    drop_nxt      = 1'b0;
    key_nxt       = key_q;
    lut_index_nxt = lut_index_q;
    freq_nxt      = freq_q;
    gate_nxt      = gate_q;
    load_nxt      = '0;
    keys_nxt      = keys_q;
    ages_nxt      = ages_q;
    case (state)
      IDLE: begin
        if (accept_c) begin
          key_nxt = key_in_c;
          if (bus.ev_note > 4'(NOTES_PER_OCTAVE - 1)) begin
            state_nxt = REJECT;
            drop_nxt  = 1'b1;
          end else if (bus.ev_on) begin
            state_nxt     = LOOKUP;
            lut_index_nxt = key_in_c;
          end else begin
            state_nxt = RELEASE;
          end
        end
      end
      LOOKUP: state_nxt = WRITE;
      WRITE: begin
        state_nxt = IDLE;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
          if (IDX_W'(v) == target_c) begin
            freq_nxt[v] = bus.lut_freq;
            gate_nxt[v] = 1'b1;
            ages_nxt[v] = '0;
            keys_nxt[v] = key_q;
            load_nxt[v] = 1'b1;
          end else if (gate_q[v] && (ages_q[v] != AGE_MAX)) begin
            ages_nxt[v] = ages_q[v] + AGE_W'(1);
          end
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
          if (gate_q[v] && (keys_q[v] == key_q)) begin
            gate_nxt[v] = 1'b0;
          end
        end
      end
      REJECT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ev_ready   = ev_ready_q;
  assign bus.drop       = drop_q;
  assign bus.lut_index  = lut_index_q;
  assign bus.voice_freq = freq_q;
  assign bus.voice_gate = gate_q;
  assign bus.voice_load = load_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator against a behavioural voice-pool model.
module tb_voice_allocator;

  localparam int unsigned NV = 4;
  localparam int unsigned FW = 21;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  voice_allocator_if #(.NUM_VOICES(NV), .FREQ_W(FW)) bus ();

  voice_allocator #(.NUM_VOICES(NV), .FREQ_W(FW), .AGE_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Registered frequency table: data valid one cycle after the index
  logic [FW-1:0] tbl [128];
  always @(posedge clk) bus.lut_freq <= tbl[bus.lut_index];

  int checks = 0;
  int errors = 0;

  // Reference voice pool
  logic [FW-1:0] m_freq [NV];
  bit            m_gate [NV];
  int            m_age  [NV];
  int            m_key  [NV];
  int            m_lut;
  int            last_target;

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_freq[v] = '0; m_gate[v] = 1'b0; m_age[v] = 0; m_key[v] = 0;
    end
    m_lut = 0;
    last_target = 0;
  endfunction

  function automatic void model_on(int k);
    int t;
    t = -1;
    for (int v = 0; v < NV; v++) if (t < 0 && m_gate[v] && m_key[v] == k) t = v;
    for (int v = 0; v < NV; v++) if (t < 0 && !m_gate[v]) t = v;
    if (t < 0) begin
      t = 0;
      for (int v = 1; v < NV; v++) if (m_age[v] > m_age[t]) t = v;
    end
    for (int v = 0; v < NV; v++)
      if (v != t && m_gate[v] && m_age[v] < (1 << AW) - 1) m_age[v]++;
    m_freq[t] = tbl[k]; m_gate[t] = 1'b1; m_age[t] = 0; m_key[t] = k;
    last_target = t;
    m_lut = k;
  endfunction

  function automatic void model_off(int k);
    for (int v = 0; v < NV; v++) if (m_gate[v] && m_key[v] == k) m_gate[v] = 1'b0;
  endfunction

  function automatic logic [NV*FW-1:0] exp_freq();
    logic [NV*FW-1:0] r;
    for (int v = 0; v < NV; v++) r[v*FW +: FW] = m_freq[v];
    return r;
  endfunction

  function automatic logic [NV-1:0] exp_gate();
    logic [NV-1:0] r;
    for (int v = 0; v < NV; v++) r[v] = m_gate[v];
    return r;
  endfunction

  // Waits (bounded) for ev_ready at a falling edge, presents one event, returns at the T+1 falling edge
  task automatic send(input bit on, input int note, input int oct);
    int n;
    n = 0;
    while (bus.ev_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_wait_ready: ev_ready=%b required 1 after %0d cycles", bus.ev_ready, n);
    end
    bus.ev_valid  = 1'b1;
    bus.ev_on     = on;
    bus.ev_note   = 4'(note);
    bus.ev_octave = 3'(oct);
    @(negedge clk);
    bus.ev_valid  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.ev_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ev_valid = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    checks++;
    if (bus.voice_freq !== '0 || bus.voice_gate !== '0 || bus.voice_load !== '0) begin
      errors++;
      $display("FAIL reset_voices: freq=%h gate=%b load=%b required all 0",
               bus.voice_freq, bus.voice_gate, bus.voice_load);
    end
    checks++;
    if (bus.ev_ready !== 1'b1 || bus.lut_index !== 7'd0 || bus.drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b lut_index=%0d drop=%b required 1/0/0",
               bus.ev_ready, bus.lut_index, bus.drop);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: ev_ready=%b required 1", bus.ev_ready);
    end
  endtask

  task automatic test_basic_on();
    do_reset();
    tbl[57] = 21'd44000;
    send(1'b1, 9, 4);
    checks++;
    if (bus.lut_index !== 7'd57 || bus.ev_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_lookup: lut_index=%0d ready=%b required 57/0", bus.lut_index, bus.ev_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.ev_ready !== 1'b0 || bus.voice_load !== '0) begin
      errors++;
      $display("FAIL basic_write: ready=%b load=%b required 0/0000", bus.ev_ready, bus.voice_load);
    end
    @(negedge clk);
    model_on(57);
    checks++;
    if (bus.voice_freq[0 +: FW] !== 21'd44000 || bus.voice_gate !== 4'b0001 ||
        bus.voice_load !== 4'b0001 || bus.ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_result: freq0=%0d gate=%b load=%b ready=%b required 44000/0001/0001/1",
               bus.voice_freq[0 +: FW], bus.voice_gate, bus.voice_load, bus.ev_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.voice_load !== '0 || bus.voice_freq !== exp_freq()) begin
      errors++;
      $display("FAIL basic_load_pulse: load=%b freq=%h required 0000/%h",
               bus.voice_load, bus.voice_freq, exp_freq());
    end
  endtask

  task automatic test_on_off();
    do_reset();
    tbl[0] = 21'd1635;
    tbl[2] = 21'd1835;
    send(1'b1, 0, 0); repeat (2) @(negedge clk); model_on(0);
    send(1'b1, 2, 0); repeat (2) @(negedge clk); model_on(2);
    checks++;
    if (bus.voice_freq[0 +: FW] !== 21'd1635 || bus.voice_freq[FW +: FW] !== 21'd1835 ||
        bus.voice_gate !== 4'b0011) begin
      errors++;
      $display("FAIL on_off_two_voices: f0=%0d f1=%0d gate=%b required 1635/1835/0011",
               bus.voice_freq[0 +: FW], bus.voice_freq[FW +: FW], bus.voice_gate);
    end
    send(1'b0, 0, 0);
    checks++;
    if (bus.ev_ready !== 1'b0 || bus.voice_gate !== 4'b0011) begin
      errors++;
      $display("FAIL on_off_release_cycle: ready=%b gate=%b required 0/0011", bus.ev_ready, bus.voice_gate);
    end
    @(negedge clk);
    model_off(0);
    checks++;
    if (bus.voice_gate !== 4'b0010 || bus.voice_freq !== exp_freq() || bus.ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL on_off_released: gate=%b freq=%h ready=%b required 0010/%h/1",
               bus.voice_gate, bus.voice_freq, bus.ev_ready, exp_freq());
    end
  endtask

  task automatic test_steal();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 0, i); repeat (2) @(negedge clk); model_on(i * 12);
    end
    send(1'b1, 0, 4); repeat (2) @(negedge clk); model_on(48);
    checks++;
    if (bus.voice_load !== 4'b0001 || bus.voice_freq[0 +: FW] !== tbl[48] || bus.voice_gate !== 4'b1111) begin
      errors++;
      $display("FAIL steal_oldest: load=%b freq0=%0d gate=%b required 0001/%0d/1111",
               bus.voice_load, bus.voice_freq[0 +: FW], bus.voice_gate, tbl[48]);
    end
    // voice 1 is now the oldest, which only holds if the others aged on the last write
    send(1'b1, 0, 5); repeat (2) @(negedge clk); model_on(60);
    checks++;
    if (bus.voice_load !== 4'b0010 || bus.voice_freq !== exp_freq()) begin
      errors++;
      $display("FAIL steal_next: load=%b freq=%h required 0010/%h", bus.voice_load, bus.voice_freq, exp_freq());
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    send(1'b1, 9, 4); repeat (2) @(negedge clk); model_on(57);
    send(1'b1, 9, 4);
    checks++;
    if (bus.voice_load !== '0) begin
      errors++;
      $display("FAIL retrig_gap: load=%b required 0000", bus.voice_load);
    end
    repeat (2) @(negedge clk); model_on(57);
    checks++;
    if (bus.voice_load !== 4'b0001 || bus.voice_gate !== 4'b0001 || bus.voice_freq !== exp_freq()) begin
      errors++;
      $display("FAIL retrig_same_voice: load=%b gate=%b required 0001/0001", bus.voice_load, bus.voice_gate);
    end
  endtask

  task automatic test_reject();
    do_reset();
    send(1'b1, 5, 1); repeat (2) @(negedge clk); model_on(17);
    send(1'b1, 13, 2);
    checks++;
    if (bus.drop !== 1'b1 || bus.ev_ready !== 1'b0 || bus.lut_index !== 7'd17) begin
      errors++;
      $display("FAIL reject_drop: drop=%b ready=%b lut_index=%0d required 1/0/17",
               bus.drop, bus.ev_ready, bus.lut_index);
    end
    @(negedge clk);
    checks++;
    if (bus.drop !== 1'b0 || bus.ev_ready !== 1'b1 || bus.voice_gate !== exp_gate() ||
        bus.voice_freq !== exp_freq() || bus.voice_load !== '0) begin
      errors++;
      $display("FAIL reject_after: drop=%b ready=%b gate=%b load=%b required 0/1/%b/0000",
               bus.drop, bus.ev_ready, bus.voice_gate, bus.voice_load, exp_gate());
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    send(1'b1, 3, 3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.voice_load !== '0 || bus.voice_gate !== '0 || bus.voice_freq !== '0 ||
        bus.ev_ready !== 1'b1 || bus.lut_index !== 7'd0 || bus.drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_write: load=%b gate=%b freq=%h ready=%b lut_index=%0d required 0/0/0/1/0",
               bus.voice_load, bus.voice_gate, bus.voice_freq, bus.ev_ready, bus.lut_index);
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_random();
    int note, oct, k;
    bit on;
    do_reset();
    for (int i = 0; i < 120; i++) begin
      on   = ($urandom_range(0, 9) < 6);
      note = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 15)) : int'($urandom_range(0, 11));
      oct  = int'($urandom_range(0, 1));
      k    = oct * 12 + note;
      send(on, note, oct);
      if (note > 11) begin
        checks++;
        if (bus.drop !== 1'b1 || bus.lut_index !== 7'(m_lut)) begin
          errors++;
          $display("FAIL rand_reject[%0d]: drop=%b lut_index=%0d required 1/%0d", i, bus.drop, bus.lut_index, m_lut);
        end
        @(negedge clk);
      end else if (on) begin
        checks++;
        if (bus.lut_index !== 7'(k) || bus.voice_load !== '0) begin
          errors++;
          $display("FAIL rand_lookup[%0d]: lut_index=%0d load=%b required %0d/0000", i, bus.lut_index, bus.voice_load, k);
        end
        repeat (2) @(negedge clk);
        model_on(k);
        checks++;
        if (bus.voice_freq !== exp_freq() || bus.voice_gate !== exp_gate() ||
            bus.voice_load !== (NV'(1) << last_target)) begin
          errors++;
          $display("FAIL rand_on[%0d]: freq=%h gate=%b load=%b required %h/%b/%b", i, bus.voice_freq,
                   bus.voice_gate, bus.voice_load, exp_freq(), exp_gate(), NV'(1) << last_target);
        end
      end else begin
        @(negedge clk);
        model_off(k);
        checks++;
        if (bus.voice_gate !== exp_gate() || bus.voice_freq !== exp_freq() || bus.ev_ready !== 1'b1) begin
          errors++;
          $display("FAIL rand_off[%0d]: gate=%b ready=%b required %b/1", i, bus.voice_gate, bus.ev_ready, exp_gate());
        end
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.ev_valid  = 1'b0;
    bus.ev_on     = 1'b0;
    bus.ev_note   = '0;
    bus.ev_octave = '0;
    for (int i = 0; i < 128; i++) tbl[i] = FW'($urandom_range(1, (1 << FW) - 1));
    test_reset();
    test_basic_on();
    test_on_off();
    test_steal();
    test_retrigger();
    test_reject();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
